// File: rtl/cola_fetch.sv
// Fetch-to-decode instruction queue of {pc, instr} entries with flush; optional COLA_FETCH_BYPASS_EN.
// Latency: 1 cycle push-to-head (0 cycles through an empty queue when COLA_FETCH_BYPASS_EN is defined).
// Backpressure: listo_out drops when full (even if a pop occurs the same cycle); head holds while !listo_in.
module cola_fetch #(
    parameter int PROFUNDIDAD = 4,
    parameter int ANCHO       = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ANCHO-1:0]               instr_in,
    input  logic [ANCHO-1:0]               pc_in,
    input  logic                           valido_in,
    output logic                           listo_out,
    input  logic                           flush,
    output logic [ANCHO-1:0]               instr_out,
    output logic [ANCHO-1:0]               pc_out,
    output logic                           valido_out,
    input  logic                           listo_in,
    output logic [5:0]                     opcode,
    output logic [4:0]                     rs,
    output logic [4:0]                     rt,
    output logic [4:0]                     rd,
    output logic [5:0]                     funct,
    output logic [15:0]                    inmediato,
    output logic [$clog2(PROFUNDIDAD):0]   ocupacion
);
    localparam int PW = $clog2(PROFUNDIDAD);

    logic [ANCHO-1:0] mem_instr [PROFUNDIDAD];
    logic [ANCHO-1:0] mem_pc    [PROFUNDIDAD];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             push;
    logic             pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == (PW+1)'(PROFUNDIDAD));

`ifdef COLA_FETCH_BYPASS_EN
    // Entry goes straight to decode and is never written into the array.
    assign bypass = empty && valido_in && listo_in && !flush && !rst;
`else
    assign bypass = 1'b0;
`endif

    assign listo_out = !rst && !full;
    assign push      = valido_in && listo_out && !flush && !bypass;
    assign pop       = !empty && listo_in && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                cnt <= cnt + (PW+1)'(1);
            else if (pop && !push)
                cnt <= cnt - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= instr_in;
            mem_pc[wr_ptr]    <= pc_in;
        end
    end

    always_comb begin
        instr_out = '0;
        pc_out    = '0;
        if (!empty) begin
            instr_out = mem_instr[rd_ptr];
            pc_out    = mem_pc[rd_ptr];
        end else if (bypass) begin
            instr_out = instr_in;
            pc_out    = pc_in;
        end
    end

    assign valido_out = !empty || bypass;
    assign ocupacion  = cnt;

    assign opcode    = instr_out[31:26];
    assign rs        = instr_out[25:21];
    assign rt        = instr_out[20:16];
    assign rd        = instr_out[15:11];
    assign funct     = instr_out[5:0];
    assign inmediato = instr_out[15:0];
endmodule

// File: tb/tb_cola_fetch.sv
// Directed bench for cola_fetch with a {pc, instr} scoreboard queue as reference model.
module tb_cola_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic        valido_in = 1'b0;
    logic        listo_out;
    logic        flush = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valido_out;
    logic        listo_in = 1'b0;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] inmediato;
    logic [2:0]  ocupacion;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];

    cola_fetch #(.PROFUNDIDAD(4), .ANCHO(32)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
        .valido_in(valido_in), .listo_out(listo_out), .flush(flush),
        .instr_out(instr_out), .pc_out(pc_out), .valido_out(valido_out),
        .listo_in(listo_in), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .funct(funct), .inmediato(inmediato), .ocupacion(ocupacion)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the edge, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic r, input logic vin, input logic [31:0] ins,
                         input logic [31:0] pcv, input logic lin, input logic fl);
        logic [63:0] head;
        logic        byp;
        int          n;
        @(posedge clk);
        #1;
        rst = r; valido_in = vin; instr_in = ins; pc_in = pcv; listo_in = lin; flush = fl;
        #1;
        n    = sb.size();
        byp  = 1'b0;
`ifdef COLA_FETCH_BYPASS_EN
        byp  = (n == 0) && vin && lin && !fl && !r;
`endif
        head = (n != 0) ? sb[0] : (byp ? {pcv, ins} : 64'h0);
        chk("listo_out", listo_out, !r && (n != 4));
        chk("valido_out", valido_out, (n != 0) || byp);
        chk("ocupacion", ocupacion, n);
        chk("pc_out", pc_out, head[63:32]);
        chk("instr_out", instr_out, head[31:0]);
        if (r || fl) begin
            sb.delete();
        end else if (!byp) begin
            if (n != 0 && lin)
                void'(sb.pop_front());
            if (vin && n != 4)
                sb.push_back({pcv, ins});
        end
    endtask

    initial begin
        // Reset
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 32'hdead_beef, 32'h100, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("rst_opcode", opcode, 6'h0);

        // Single push, decoded fields next cycle
        cycle(0, 1, 32'h8C22_0004, 32'h0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("opcode", opcode, 6'h23);
        chk("rs", rs, 5'd1);
        chk("rt", rt, 5'd2);
        chk("inmediato", inmediato, 16'h0004);
        cycle(0, 0, 0, 0, 1, 0);

        // Fill to full; fifth push and a push coinciding with a pop are refused
        for (int i = 0; i < 5; i++)
            cycle(0, 1, 32'h1000_0000 | 32'(i * 4), 32'(i * 4), 0, 0);
        cycle(0, 1, 32'h2000_0010, 32'h10, 1, 0);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("drained_funct", funct, 6'h0);

        // Streaming push+pop across pointer wrap
        for (int i = 0; i < 10; i++)
            cycle(0, 1, 32'h3000_0000 | 32'(i * 4), 32'(i * 4), (i != 0), 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Flush with concurrent push and pop request
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 32'h4000_0000 | 32'(i), 32'(i * 4), 0, 0);
        cycle(0, 1, 32'h4444_0040, 32'h40, 1, 1);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // Reset mid-operation
        cycle(0, 1, 32'h5000_0000, 32'h0, 0, 0);
        cycle(0, 1, 32'h5000_0004, 32'h4, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Empty queue with both sides ready: bypass, or one-cycle latency without it
        cycle(0, 1, 32'h0085_1020, 32'h200, 1, 0);
`ifdef COLA_FETCH_BYPASS_EN
        chk("byp_funct", funct, 6'h20);
        chk("byp_rd", rd, 5'd2);
`else
        chk("nobyp_funct", funct, 6'h00);
`endif
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cola_fetch.md
# cola_fetch

Instruction queue between the fetch stage (PC, instruction memory, PC+4 adder) and decode. Captures each fetched instruction word with its PC into a small FIFO and decouples fetch from decode stalls via valid/ready handshakes on both sides. Presents the head entry to decode together with its MIPS-style field slices. A single-cycle flush discards everything in flight on a branch or jump.

## Interface
- PROFUNDIDAD, 4, number of entries; power of two, ≥2
- ANCHO, 32, instruction and PC width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- instr_in  input  ANCHO  instruction word from instruction memory
- pc_in  input  ANCHO  PC of instr_in
- valido_in  input  1  fetch offers an entry this cycle
- listo_out  output  1  queue accepts a push this cycle
- flush  input  1  discard all entries
- instr_out  output  ANCHO  head instruction
- pc_out  output  ANCHO  head PC
- valido_out  output  1  head entry valid
- listo_in  input  1  decode consumes head this cycle
- opcode  output  6  instr_out[31:26]
- rs  output  5  instr_out[25:21]
- rt  output  5  instr_out[20:16]
- rd  output  5  instr_out[15:11]
- funct  output  6  instr_out[5:0]
- inmediato  output  16  instr_out[15:0]
- ocupacion  output  $clog2(PROFUNDIDAD)+1  entries currently stored

## Operation
- Storage: PROFUNDIDAD-entry array of {pc, instr}; write pointer, read pointer, counter; pointers wrap modulo PROFUNDIDAD.
- Push: valido_in && listo_out → write at write pointer, advance it.
- Pop: valido_out && listo_in → advance read pointer.
- listo_out = !rst && (ocupacion != PROFUNDIDAD). Full queue refuses push even if a pop occurs the same cycle.
- valido_out = (ocupacion != 0). Head outputs read combinationally from the array at the read pointer.
- When empty, instr_out and pc_out are forced to 0, so all field slices are 0.
- Simultaneous push and pop (not full, not empty): ocupacion unchanged, both pointers advance.
- Flush priority: pointers and ocupacion go to 0. Any push or pop in the same cycle is ignored. The queue is empty the next cycle.
- Data and PC pass through unmodified; no decoding beyond bit slicing.

## Timing
- Reset (rst high at a rising edge): pointers = 0, ocupacion = 0, valido_out = 0, instr_out = pc_out = 0.
- listo_out is 0 during any cycle with rst high, and 1 from the first cycle after reset.
- Reset mid-operation discards all contents, with the same result as flush.
- Push latency: an entry pushed at edge N is visible on instr_out/valido_out after edge N, in cycle N+1.
- Pop: the head advances after the edge where the pop occurs. The next entry is presented in the following cycle with no bubble.
- Sustained throughput: 1 entry/cycle when both sides hold valid/ready high.
- Handshake: valid and ready are independent. Neither side waits for the other before asserting. Data must stay stable while valid && !ready.
- ocupacion updates on the same edge as the push/pop/flush.

## Configuration
- COLA_FETCH_BYPASS_EN defined:
  - When the queue is empty, valido_in is 1, flush is 0 and listo_in is 1, instr_in/pc_in drive instr_out/pc_out combinationally and valido_out = 1 in that same cycle.
  - The entry is consumed without being written; pointers and ocupacion are unchanged.
  - Zero-cycle latency through an empty queue.
- Not defined: no combinational path from input to output. Minimum latency is 1 cycle and valido_out depends only on registered state.

## Test plan
- Reset, then push 0x8C220004 @ pc 0x00000000 with listo_in=0 → next cycle: valido_out=1, instr_out=0x8C220004, opcode=0x23, rs=1, rt=2, inmediato=0x0004, ocupacion=1.
- Push 4 entries (pc 0,4,8,12), listo_in=0 → listo_out=0 and ocupacion=4. A fifth push with pc 16 is ignored. Then listo_in=1 for 4 cycles → pc_out 0,4,8,12 in order, then valido_out=0 and instr_out=0.
- Push and pop every cycle for 10 cycles (pc 0..36 step 4) → ocupacion stays 1 and pc_out lags pc_in by one cycle, covering pointer wrap.
- 3 entries stored, assert flush together with a push of pc 0x40 → next cycle ocupacion=0 and valido_out=0. pc 0x40 never appears.
- 2 entries stored, assert rst for one cycle → listo_out=0 during reset. After it, ocupacion=0, valido_out=0 and listo_out=1.
- COLA_FETCH_BYPASS_EN, empty, push 0x00851020 with listo_in=1 → same cycle: valido_out=1, funct=0x20, rd=2. Next cycle: ocupacion=0.
